// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Central sequencer for the five-stage pipeline. Every cycle it decides which
// stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC advance, which
// freeze and which capture a bubble. The decision comes from the MEM-stage
// data handshake, MEM-stage redirects, ID/EX load-use hazards, fetch wait and
// halt.
//
// Optional feature: define PIPE_PERF_CNT_EN to build the stall/flush
// performance counters. Without it both counter outputs are tied to zero.
//
// Ports:
//   CLK, nRST                       clock, asynchronous active-low reset
//   ihit                            instruction fetch completes this cycle
//   dhit                            MEM-stage data access completes this cycle
//   exmem_dren, exmem_dwen          MEM-stage instruction reads / writes memory
//   exmem_br_taken, exmem_jump      MEM-stage redirect (taken branch / jump)
//   exmem_halt                      halt instruction is in MEM
//   idex_memtoReg, idex_wsel        EX-stage load and its destination register
//   ifid_rs, ifid_rt                ID-stage source registers
//   pc_en, *_en, *_flush            stage register enables and bubble selects
//   halt                            processor halted (registered, sticky)
//   stall_cnt, flush_cnt            performance counters
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dren,
  input  logic             exmem_dwen,
  input  logic             exmem_br_taken,
  input  logic [1:0]       exmem_jump,
  input  logic             exmem_halt,
  input  logic             idex_memtoReg,
  input  logic [REG_W-1:0] idex_wsel,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Sequencer state
  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DWAIT  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  // Winning decode rule for the current cycle, highest priority first
  localparam logic [2:0] R_RESET  = 3'd0;
  localparam logic [2:0] R_HALTED = 3'd1;
  localparam logic [2:0] R_DSTALL = 3'd2;
  localparam logic [2:0] R_DRAIN  = 3'd3;
  localparam logic [2:0] R_REDIR  = 3'd4;
  localparam logic [2:0] R_LUSE   = 3'd5;
  localparam logic [2:0] R_FWAIT  = 3'd6;
  localparam logic [2:0] R_NORMAL = 3'd7;

  logic [1:0] state, next_state;
  logic [2:0] rule;
  logic       halt_q;
  logic       data_stall, redirect, load_use;

  assign data_stall = (exmem_dren | exmem_dwen) & ~dhit;
  assign redirect   = exmem_br_taken | (exmem_jump != 2'b00);
  // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use   = idex_memtoReg & (idex_wsel != '0) &
                      ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));

  // Priority encoder. DWAIT decodes like RUN: the stall simply persists while
  // dhit stays low, and the dhit cycle falls through to the lower rules.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    rule = R_NORMAL;
    if (!nRST)                  rule = R_RESET;
    else if (state == HALTED)   rule = R_HALTED;
    else if (data_stall)        rule = R_DSTALL;
    else if (exmem_halt)        rule = R_DRAIN;
    else if (redirect)          rule = R_REDIR;
    else if (load_use)          rule = R_LUSE;
    else if (!ihit)             rule = R_FWAIT;
  end

  // Output and next-state decode
  always_comb begin
    next_state  = RUN;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    case (rule)
      R_RESET: begin
        next_state = state;
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
      end
      R_HALTED: begin
        next_state = HALTED;
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      end
      R_DSTALL: begin
        // Front of the pipe freezes; WB gets a bubble so it never retires twice.
        next_state = DWAIT;
        {pc_en, ifid_en, idex_en, exmem_en} = '0;
        memwb_flush = 1'b1;
      end
      R_DRAIN: begin
        // Only the halt instruction itself moves on into WB.
        next_state = HALTED;
        {pc_en, ifid_en, idex_en, exmem_en} = '0;
      end
      R_REDIR: begin
        // PC loads the target even if the current fetch has not returned.
        {ifid_flush, idex_flush, exmem_flush} = '1;
      end
      R_LUSE: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      R_FWAIT: begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!nRST) begin
      state  <= RUN;
      halt_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == HALTED) halt_q <= 1'b1;
    end
  end

  assign halt = halt_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Counters wrap naturally; HALTED decodes to R_HALTED so both freeze there.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (rule == R_DSTALL || rule == R_LUSE || rule == R_FWAIT) stall_q <= stall_q + 1'b1;
      if (rule == R_REDIR) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  typedef enum {C_RST, C_NORM, C_DSTALL, C_DRAIN, C_REDIR, C_LUSE, C_FWAIT, C_HALTED} cls_t;

  typedef struct {
    logic             ihit, dhit, dren, dwen, br;
    logic [1:0]       jump;
    logic             xhalt, mtr;
    logic [REG_W-1:0] wsel, rs, rt;
    cls_t             cls;
  } stim_t;

  logic             CLK, nRST;
  logic             ihit, dhit, exmem_dren, exmem_dwen, exmem_br_taken, exmem_halt, idex_memtoReg;
  logic [1:0]       exmem_jump;
  logic [REG_W-1:0] idex_wsel, ifid_rs, ifid_rt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen), .exmem_br_taken(exmem_br_taken),
    .exmem_jump(exmem_jump), .exmem_halt(exmem_halt), .idex_memtoReg(idex_memtoReg),
    .idex_wsel(idex_wsel), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
  logic [8:0] obs;
  assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};

  logic [8:0]       sb[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_stall, exp_flush;
  logic             exp_halt;
  cls_t             last_cls;
  logic [8:0]       want;

  function automatic logic [8:0] exp_vec(cls_t c);
    case (c)
      C_RST:    return 9'b0_0000_1111;
      C_NORM:   return 9'b1_1111_0000;
      C_DSTALL: return 9'b0_0001_0001;
      C_DRAIN:  return 9'b0_0001_0000;
      C_REDIR:  return 9'b1_1111_1110;
      C_LUSE:   return 9'b0_0111_0100;
      C_FWAIT:  return 9'b0_1111_1000;
      default:  return 9'b0_0000_0000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] want_stall();
`ifdef PIPE_PERF_CNT_EN
    return exp_stall;
`else
    return '0;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] want_flush();
`ifdef PIPE_PERF_CNT_EN
    return exp_flush;
`else
    return '0;
`endif
  endfunction

  function automatic stim_t mk(logic ih, logic dh, logic rd, logic wr, logic br, logic [1:0] jp,
                               logic xh, logic mtr, int ws, int rs, int rt, cls_t c);
    stim_t s;
    s.ihit = ih; s.dhit = dh; s.dren = rd; s.dwen = wr; s.br = br; s.jump = jp;
    s.xhalt = xh; s.mtr = mtr;
    s.wsel = REG_W'(ws); s.rs = REG_W'(rs); s.rt = REG_W'(rt); s.cls = c;
    return s;
  endfunction

  // Drives one cycle of stimulus just after the edge and queues the expected
  // control vector; returns at the falling edge where outputs are sampled.
  task automatic drive_cycle(input stim_t s);
    @(posedge CLK);
    case (last_cls)
      C_DSTALL, C_LUSE, C_FWAIT: exp_stall = exp_stall + 1;
      C_REDIR:                   exp_flush = exp_flush + 1;
      C_DRAIN:                   exp_halt  = 1'b1;
      default: ;
    endcase
    #1;
    ihit = s.ihit; dhit = s.dhit; exmem_dren = s.dren; exmem_dwen = s.dwen;
    exmem_br_taken = s.br; exmem_jump = s.jump; exmem_halt = s.xhalt;
    idex_memtoReg = s.mtr; idex_wsel = s.wsel; ifid_rs = s.rs; ifid_rt = s.rt;
    sb.push_back(exp_vec(s.cls));
    last_cls = s.cls;
    @(negedge CLK);
  endtask

  task automatic reset_assert();
    nRST = 1'b0;
    ihit = 1'b1; dhit = 1'b0; exmem_dren = 1'b0; exmem_dwen = 1'b0; exmem_br_taken = 1'b0;
    exmem_jump = 2'b00; exmem_halt = 1'b0; idex_memtoReg = 1'b0;
    idex_wsel = '0; ifid_rs = '0; ifid_rt = '0;
    exp_stall = '0; exp_flush = '0; exp_halt = 1'b0; last_cls = C_RST;
    sb.push_back(exp_vec(C_RST));
    #1;
  endtask

  task automatic reset_release();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    reset_assert();
    want = sb.pop_front();
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL reset ctrl: got %b, expected %b", obs, want); end
    n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset halt: got %b, expected 0", halt); end
    n_checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin
      n_fail++; $display("FAIL reset counters: got %0d/%0d, expected 0/0", stall_cnt, flush_cnt); end
    reset_release();
  endtask

  task automatic test_normal();
    stim_t tbl[$];
    tbl = '{mk(1,0,0,0,0,0,0,0,0,0,0,C_NORM), mk(1,0,0,0,0,0,0,0,3,3,3,C_NORM),
            mk(1,1,0,0,0,0,0,0,7,1,2,C_NORM), mk(1,0,0,0,0,0,0,0,0,0,0,C_NORM)};
    foreach (tbl[i]) begin
      drive_cycle(tbl[i]);
      want = sb.pop_front();
      n_checks++; if (obs !== want) begin n_fail++; $display("FAIL normal[%0d] ctrl: got %b, expected %b", i, obs, want); end
      n_checks++; if (halt !== exp_halt) begin n_fail++; $display("FAIL normal[%0d] halt: got %b, expected %b", i, halt, exp_halt); end
    end
  endtask

  task automatic test_data_wait();
    stim_t tbl[$];
    tbl = '{mk(1,0,1,0,0,0,0,0,0,0,0,C_DSTALL), mk(1,0,1,0,0,0,0,0,0,0,0,C_DSTALL),
            mk(1,0,1,0,0,0,0,0,0,0,0,C_DSTALL), mk(1,1,1,0,0,0,0,0,0,0,0,C_NORM),
            mk(1,0,0,0,0,0,0,0,0,0,0,C_NORM),   mk(0,0,0,1,0,0,0,0,0,0,0,C_DSTALL),
            mk(0,1,0,1,0,0,0,0,0,0,0,C_FWAIT),  mk(1,0,0,0,0,0,0,0,0,0,0,C_NORM)};
    foreach (tbl[i]) begin
      drive_cycle(tbl[i]);
      want = sb.pop_front();
      n_checks++; if (obs !== want) begin n_fail++; $display("FAIL dwait[%0d] ctrl: got %b, expected %b", i, obs, want); end
      n_checks++; if (stall_cnt !== want_stall() || flush_cnt !== want_flush()) begin
        n_fail++; $display("FAIL dwait[%0d] counters: got %0d/%0d, expected %0d/%0d",
                           i, stall_cnt, flush_cnt, want_stall(), want_flush()); end
    end
  endtask

  task automatic test_load_use();
    stim_t tbl[$];
    tbl = '{mk(1,0,0,0,0,0,0,1,8,0,8,C_LUSE),   mk(1,0,0,0,0,0,0,1,0,0,0,C_NORM),
            mk(1,0,0,0,0,0,0,1,3,3,7,C_LUSE),   mk(1,0,0,0,0,0,0,0,8,8,8,C_NORM),
            mk(1,0,0,0,0,0,0,1,31,31,0,C_LUSE), mk(1,0,0,0,0,0,0,1,8,1,9,C_NORM),
            mk(0,0,0,0,0,0,0,1,6,6,6,C_LUSE),   mk(1,0,0,0,0,0,0,0,0,0,0,C_NORM)};
    foreach (tbl[i]) begin
      drive_cycle(tbl[i]);
      want = sb.pop_front();
      n_checks++; if (obs !== want) begin n_fail++; $display("FAIL loaduse[%0d] ctrl: got %b, expected %b", i, obs, want); end
      n_checks++; if (stall_cnt !== want_stall() || flush_cnt !== want_flush()) begin
        n_fail++; $display("FAIL loaduse[%0d] counters: got %0d/%0d, expected %0d/%0d",
                           i, stall_cnt, flush_cnt, want_stall(), want_flush()); end
    end
  endtask

  task automatic test_redirect();
    stim_t tbl[$];
    tbl = '{mk(0,0,0,0,0,2,0,0,0,0,0,C_REDIR), mk(1,0,0,0,1,0,0,0,0,0,0,C_REDIR),
            mk(1,0,0,0,0,1,0,1,4,4,0,C_REDIR), mk(0,0,0,0,0,0,0,0,0,0,0,C_FWAIT),
            mk(1,0,0,0,0,3,0,0,0,0,0,C_REDIR), mk(1,0,0,0,0,0,0,0,0,0,0,C_NORM),
            mk(1,0,0,0,0,0,0,0,0,0,0,C_NORM)};
    foreach (tbl[i]) begin
      drive_cycle(tbl[i]);
      want = sb.pop_front();
      n_checks++; if (obs !== want) begin n_fail++; $display("FAIL redirect[%0d] ctrl: got %b, expected %b", i, obs, want); end
      n_checks++; if (stall_cnt !== want_stall() || flush_cnt !== want_flush()) begin
        n_fail++; $display("FAIL redirect[%0d] counters: got %0d/%0d, expected %0d/%0d",
                           i, stall_cnt, flush_cnt, want_stall(), want_flush()); end
    end
  endtask

  task automatic test_priority();
    stim_t tbl[$];
    tbl = '{mk(1,0,0,1,1,0,0,0,0,0,0,C_DSTALL), mk(1,1,0,1,1,0,0,0,0,0,0,C_REDIR),
            mk(1,0,1,0,0,0,1,0,0,0,0,C_DSTALL), mk(1,0,1,0,0,0,0,1,5,0,5,C_DSTALL),
            mk(1,1,1,0,0,0,0,1,5,0,5,C_LUSE),   mk(1,0,1,0,0,2,0,0,0,0,0,C_DSTALL),
            mk(1,1,1,0,0,2,0,0,0,0,0,C_REDIR),  mk(1,0,0,0,0,0,0,0,0,0,0,C_NORM)};
    foreach (tbl[i]) begin
      drive_cycle(tbl[i]);
      want = sb.pop_front();
      n_checks++; if (obs !== want) begin n_fail++; $display("FAIL priority[%0d] ctrl: got %b, expected %b", i, obs, want); end
      n_checks++; if (stall_cnt !== want_stall() || flush_cnt !== want_flush()) begin
        n_fail++; $display("FAIL priority[%0d] counters: got %0d/%0d, expected %0d/%0d",
                           i, stall_cnt, flush_cnt, want_stall(), want_flush()); end
    end
  endtask

  task automatic test_halt();
    stim_t tbl[$];
    tbl = '{mk(1,0,0,0,1,0,1,0,0,0,0,C_DRAIN),  mk(1,0,0,0,0,0,0,0,0,0,0,C_HALTED),
            mk(0,0,1,0,0,0,0,0,0,0,0,C_HALTED), mk(1,0,0,0,1,0,0,1,2,2,0,C_HALTED),
            mk(1,1,0,0,0,0,0,0,0,0,0,C_HALTED)};
    foreach (tbl[i]) begin
      drive_cycle(tbl[i]);
      want = sb.pop_front();
      n_checks++; if (obs !== want) begin n_fail++; $display("FAIL halt[%0d] ctrl: got %b, expected %b", i, obs, want); end
      n_checks++; if (halt !== exp_halt) begin n_fail++; $display("FAIL halt[%0d] halt: got %b, expected %b", i, halt, exp_halt); end
      n_checks++; if (stall_cnt !== want_stall() || flush_cnt !== want_flush()) begin
        n_fail++; $display("FAIL halt[%0d] counters: got %0d/%0d, expected %0d/%0d",
                           i, stall_cnt, flush_cnt, want_stall(), want_flush()); end
    end
    // Asynchronous reset out of HALTED
    #2;
    reset_assert();
    want = sb.pop_front();
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL halt_rst ctrl: got %b, expected %b", obs, want); end
    n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL halt_rst halt: got %b, expected 0", halt); end
    reset_release();
    drive_cycle(mk(1,0,0,0,0,0,0,0,0,0,0,C_NORM));
    want = sb.pop_front();
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL halt_run ctrl: got %b, expected %b", obs, want); end
    n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL halt_run halt: got %b, expected 0", halt); end
  endtask

  task automatic test_reset_mid_stall();
    drive_cycle(mk(1,0,1,0,0,0,0,0,0,0,0,C_DSTALL));
    want = sb.pop_front();
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL midstall ctrl: got %b, expected %b", obs, want); end
    drive_cycle(mk(1,0,1,0,0,0,0,0,0,0,0,C_DSTALL));
    want = sb.pop_front();
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL midstall2 ctrl: got %b, expected %b", obs, want); end
    #2;
    reset_assert();
    want = sb.pop_front();
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL midstall_rst ctrl: got %b, expected %b", obs, want); end
    n_checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin
      n_fail++; $display("FAIL midstall_rst counters: got %0d/%0d, expected 0/0", stall_cnt, flush_cnt); end
    reset_release();
    drive_cycle(mk(1,0,0,0,0,0,0,0,0,0,0,C_NORM));
    want = sb.pop_front();
    n_checks++; if (obs !== want) begin n_fail++; $display("FAIL midstall_run ctrl: got %b, expected %b", obs, want); end
    n_checks++; if (stall_cnt !== want_stall() || flush_cnt !== want_flush()) begin
      n_fail++; $display("FAIL midstall_run counters: got %0d/%0d, expected %0d/%0d",
                         stall_cnt, flush_cnt, want_stall(), want_flush()); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_data_wait();
    test_load_use();
    test_redirect();
    test_priority();
    test_halt();
    test_reset_mid_stall();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
